// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: 4-digit seven-segment scan controller with a frame-committed display value,
// blanking, decimal points, leading-zero suppression, PWM dimming and a per-slot guard cycle.
module sseg_scan_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                btnC,
  input  logic                load,
  input  logic [15:0]         value,
  output logic                pend,
  input  logic                lz_en,
  input  logic [3:0]          blank_mask,
  input  logic [3:0]          dp_mask,
  input  logic [PWM_BITS-1:0] bright,
  output logic [3:0]          an,
  output logic [3:0]          hex_num,
  output logic                dp,
  output logic [1:0]          digit_idx,
  output logic                frame_tick
);
  localparam int TW = $clog2(TICK_DIV);
  logic [TW-1:0] tick_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [15:0] active, shadow;
  logic wrap, frame_end, sup, lit;
  logic [3:0] nib;
  always_comb begin
    wrap = tick_cnt == TW'(TICK_DIV - 1);
    frame_end = wrap && digit_idx == 2'd3;
    nib = active[{digit_idx, 2'b00} +: 4];
    sup = lz_en && digit_idx != 2'd0 && (active >> {digit_idx, 2'b00}) == 16'd0;
    lit = tick_cnt != '0 && !blank_mask[digit_idx] && !sup && pwm_cnt < bright;
  end
  assign frame_tick = frame_end;
  // a load coinciding with a commit keeps pend set so the new value lands next frame
  always_ff @(posedge clk or negedge btnC)
    if (!btnC) begin
      tick_cnt <= '0;
      digit_idx <= 2'd0;
      pwm_cnt <= '0;
      active <= 16'd0;
      shadow <= 16'd0;
      pend <= 1'b0;
      an <= 4'b1111;
      hex_num <= 4'd0;
      dp <= 1'b1;
    end else begin
      tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
      if (wrap) digit_idx <= digit_idx + 2'd1;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (frame_end && pend) active <= shadow;
      if (load) shadow <= value;
      pend <= load || (pend && !frame_end);
      an <= ~((4'b0001 << digit_idx) & {4{lit}});
      hex_num <= nib;
      dp <= ~(dp_mask[digit_idx] & lit);
    end
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: scoreboard bench; a cycle-count reference model predicts every output.
module tb_sseg_scan_ctrl;
  localparam int TD = 4;
  localparam int PB = 2;
  logic clk = 0, rst_n = 0, load = 0, lz_en = 0;
  logic [15:0] value = 0;
  logic [3:0] blank_mask = 0, dp_mask = 0;
  logic [PB-1:0] bright = 3;
  logic pend, dp, frame_tick;
  logic [3:0] an, hex_num;
  logic [1:0] digit_idx;
  int checks = 0, errors = 0;

  sseg_scan_ctrl #(.TICK_DIV(TD), .PWM_BITS(PB)) dut (
    .clk(clk), .btnC(rst_n), .load(load), .value(value), .pend(pend), .lz_en(lz_en),
    .blank_mask(blank_mask), .dp_mask(dp_mask), .bright(bright), .an(an), .hex_num(hex_num),
    .dp(dp), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] hex;
    logic       dp;
    logic       pend;
    logic       ft;
    logic [1:0] idx;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the scan follows from the cycle count since reset.
  int n;
  logic [15:0] m_active, m_shadow;
  logic m_pend;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n = 0; m_active = 0; m_shadow = 0; m_pend = 0;
      q.delete();
    end else begin
      int tick, d, pwm;
      logic sup, lit, fb;
      exp_t e;
      tick = n % TD;
      d = (n / TD) % 4;
      pwm = n % (1 << PB);
      sup = lz_en && d != 0 && (m_active >> (4 * d)) == 0;
      lit = tick != 0 && !blank_mask[d] && !sup && pwm < int'(bright);
      e.an = lit ? ~(4'b0001 << d) : 4'b1111;
      e.hex = 4'((m_active >> (4 * d)) & 16'hf);
      e.dp = !(dp_mask[d] && lit);
      fb = tick == TD - 1 && d == 3;
      if (fb && m_pend) begin m_active = m_shadow; m_pend = 0; end
      if (load) begin m_shadow = value; m_pend = 1; end
      n++;
      e.pend = m_pend;
      e.ft = (n % TD) == TD - 1 && ((n / TD) % 4) == 3;
      e.idx = 2'((n / TD) % 4);
      q.push_back(e);
    end

  always @(negedge clk)
    if (rst_n && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("an", 16'(an), 16'(e.an));
      chk("hex_num", 16'(hex_num), 16'(e.hex));
      chk("dp", 16'(dp), 16'(e.dp));
      chk("pend", 16'(pend), 16'(e.pend));
      chk("frame_tick", 16'(frame_tick), 16'(e.ft));
      chk("digit_idx", 16'(digit_idx), 16'(e.idx));
      chk("one_anode", 16'($countones(~an) <= 1), 16'd1);
    end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1; value = v;
    @(negedge clk);
    load = 0;
  endtask

  task automatic wait_ft();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_tick) return;
    end
    errors++;
    $display("FAIL wait_ft: no frame_tick within 40 cycles");
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"}, 16'(an), 16'hf);
    chk({tag, "_dp"}, 16'(dp), 16'd1);
    chk({tag, "_pend"}, 16'(pend), 16'd0);
    chk({tag, "_ft"}, 16'(frame_tick), 16'd0);
    chk({tag, "_hex"}, 16'(hex_num), 16'd0);
    chk({tag, "_idx"}, 16'(digit_idx), 16'd0);
  endtask

  initial begin
    cyc(3);
    chk_reset("rst");
    rst_n = 1;
    wait_ft();
    do_load(16'h1234);
    cyc(5);
    #3 rst_n = 0;
    #1 chk_reset("async_rst");
    @(negedge clk) rst_n = 1;
    do_load(16'h1234);
    wait_ft(); wait_ft(); cyc(2);
    lz_en = 1; do_load(16'h0005); wait_ft(); wait_ft();
    lz_en = 0; wait_ft();
    bright = 1; wait_ft();
    bright = 0; wait_ft();
    bright = 3;
    do_load(16'hAAAA); cyc(3); do_load(16'hBBBB); wait_ft(); wait_ft();
    do_load(16'h1111); wait_ft();
    do_load(16'hCCCC);
    chk("coinc_pend", 16'(pend), 16'd1);
    wait_ft(); wait_ft();
    blank_mask = 4'b0100; dp_mask = 4'b0001; wait_ft(); wait_ft();
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom % 8) == 0;
      value = ($urandom % 2) ? 16'($urandom) : 16'($urandom % 64);
      if ($urandom % 32 == 0) begin
        lz_en = 1'($urandom);
        blank_mask = 4'($urandom);
        dp_mask = 4'($urandom);
        bright = PB'($urandom);
      end
      @(negedge clk);
    end
    load = 0;
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
